seg7_scan: RTL and testbench

- Four-digit multiplexed seven-segment display driver, directly downstream of the clock divider.
- Consumes the divider's clk_1kHz output as a scan-rate strobe. Everything runs on the 50 MHz clkin; clk_1kHz is never used as a clock.
- Each rising edge of clk_1kHz advances the scan to the next digit and drives one digit of a frame-latched 16-bit hex value.
- A programmable anode blanking gap before each digit suppresses ghosting.

---
 rtl/seg7_scan.sv | 213 +++++++++++++++++++++
 tb/tb_seg7_scan.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed seven-segment driver.
// Runs entirely on clkin. The divider's clk_1kHz square wave is only
// sampled, never used as a clock. Each rising edge of the strobe moves the
// scan to the next digit. A programmable all-anodes-off gap before each
// digit suppresses ghosting. The displayed value is latched once per frame
// so a mid-frame update of data cannot tear the display.

`timescale 1ns/1ps

module seg7_scan #(
  parameter int BLANK_CYC = 500,  // clkin cycles with all anodes off after a digit change
  parameter int BLANK_W   = 10    // width of the blanking counter
) (
  input  logic        clkin,
  input  logic        clrn,
  input  logic        clk_1kHz,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  // Last count value spent in BLANK before moving to DRIVE. With no gap the
  // BLANK state is never entered, so the value is irrelevant in that case.
  localparam int                 LAST_I     = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
  localparam logic [BLANK_W-1:0] BLANK_LAST = LAST_I[BLANK_W-1:0];
  localparam logic               NO_GAP     = (BLANK_CYC == 0);

  // All segments off, active low.
  localparam logic [6:0] SEG_OFF = 7'b111_1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic               s1;
  logic               s2;
  logic               s3;
  logic               tick;

  logic [1:0]         idx_q;
  logic [BLANK_W-1:0] cnt_q;
  logic [15:0]        snap_q;
  logic [3:0]         dp_snap_q;

  logic [3:0]         lz_blank;
  logic [3:0]         nib;
  logic [3:0]         an_d;
  logic [6:0]         seg_d;
  logic               dp_d;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b100_0000;
      4'h1:    s = 7'b111_1001;
      4'h2:    s = 7'b010_0100;
      4'h3:    s = 7'b011_0000;
      4'h4:    s = 7'b001_1001;
      4'h5:    s = 7'b001_0010;
      4'h6:    s = 7'b000_0010;
      4'h7:    s = 7'b111_1000;
      4'h8:    s = 7'b000_0000;
      4'h9:    s = 7'b001_0000;
      4'hA:    s = 7'b000_1000;
      4'hB:    s = 7'b000_0011;
      4'hC:    s = 7'b100_0110;
      4'hD:    s = 7'b010_0001;
      4'hE:    s = 7'b000_0110;
      default: s = 7'b000_1110;
    endcase
    return s;
  endfunction

  // Two-flop synchroniser for the asynchronous strobe plus one delay flop
  // for rising-edge detection.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value
      // of its neighbour, which is what turns this into a shift chain.
      s1 <= clk_1kHz;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // One clkin cycle per rising edge of the strobe. A strobe already high at
  // reset release still yields exactly one tick because the flops reset low.
  assign tick = s2 & ~s3;

  // Scan index, frame snapshot and wrap pulse.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      idx_q     <= 2'd0;
      // NOTE: the snapshot is reset so the digits scanned before the first
      // wrap show a defined value (zero) rather than whatever powered up.
      snap_q    <= 16'h0000;
      dp_snap_q <= 4'b0000;
      frame     <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (tick) begin
        idx_q <= idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          snap_q    <= data;
          dp_snap_q <= dp_in;
          frame     <= 1'b1;
        end
      end
    end
  end

  // Blanking counter: restarts on every tick and only runs while in BLANK.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else if (tick || (state_q != BLANK)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A tick always starts a new gap, whatever the state,
  // so a strobe faster than the gap keeps re-arming the blanking.
  always_comb begin
    // NOTE: assigning a default before the case means every path drives
    // state_d, so no latch is inferred when a branch leaves it unchanged.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (tick) state_d = NO_GAP ? DRIVE : BLANK;
      end
      BLANK: begin
        if (tick) begin
          state_d = NO_GAP ? DRIVE : BLANK;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (tick) state_d = NO_GAP ? DRIVE : BLANK;
      end
      default: state_d = IDLE;
    endcase
  end

  // Leading-zero blanking on the latched frame value. Digit 0 always shows.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = blank_lz && (snap_q[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (snap_q[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (snap_q[7:4] == 4'h0);
  end

  assign nib = snap_q[{idx_q, 2'b00} +: 4];

  // Output values for the next cycle. They follow the current state, so
  // the anode goes low one cycle after DRIVE is entered; a tick blanks the
  // anodes on the very next cycle regardless of state.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if ((state_q == DRIVE) && !tick) begin
      if (!lz_blank[idx_q]) begin
        an_d[idx_q] = 1'b0;
        seg_d       = hex_to_seg(nib);
        dp_d        = ~dp_snap_q[idx_q];
      end else if (dp_snap_q[idx_q]) begin
        // Blanked digit with a decimal point: light only the point.
        an_d[idx_q] = 1'b0;
        dp_d        = 1'b0;
      end
    end
  end

  // Registered display outputs, forced dark while clrn is low.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan. Two instances share all inputs: one with the default
// 500-cycle gap and one with no gap. The strobe is driven with an 800-cycle
// period so whole frames fit in a short run. A cycle-level model derived
// from "cycles since the last tick" predicts every output of both instances.

`timescale 1ns/1ps

module tb_seg7_scan;

  localparam int HALF = 400;  // strobe half-period in clkin cycles

  logic        clkin    = 1'b0;
  logic        clrn     = 1'b0;
  logic        clk_1kHz = 1'b0;
  logic [15:0] data     = 16'h0000;
  logic [3:0]  dp_in    = 4'b0000;
  logic        blank_lz = 1'b0;

  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, frame_a, frame_b;

  seg7_scan #(.BLANK_CYC(500), .BLANK_W(10)) dut_a (
    .clkin(clkin), .clrn(clrn), .clk_1kHz(clk_1kHz), .data(data),
    .dp_in(dp_in), .blank_lz(blank_lz),
    .an(an_a), .seg(seg_a), .dp(dp_a), .frame(frame_a)
  );

  seg7_scan #(.BLANK_CYC(0), .BLANK_W(10)) dut_b (
    .clkin(clkin), .clrn(clrn), .clk_1kHz(clk_1kHz), .data(data),
    .dp_in(dp_in), .blank_lz(blank_lz),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame(frame_b)
  );

  always #10 clkin = ~clkin;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hex decode table, active low {g..a}.
  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // ---------------- behavioural model ----------------
  // m_hist holds the last three strobe samples; a tick is a rising edge seen
  // two samples late. m_since counts cycles since the last tick.
  logic [2:0]  m_hist;
  logic [1:0]  m_idx;
  logic [15:0] m_snap;
  logic [3:0]  m_dps;
  logic        m_lz;
  logic        m_started;
  int          m_since;

  always @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      m_hist    <= 3'b000;
      m_idx     <= 2'd0;
      m_snap    <= 16'h0000;
      m_dps     <= 4'b0000;
      m_lz      <= 1'b0;
      m_started <= 1'b0;
      m_since   <= 0;
    end else begin
      m_hist <= {m_hist[1:0], clk_1kHz};
      m_lz   <= blank_lz;
      if (m_hist[1] && !m_hist[2]) begin
        m_idx     <= m_idx + 2'd1;
        m_started <= 1'b1;
        m_since   <= 1;
        if (m_idx == 2'd3) begin
          m_snap <= data;
          m_dps  <= dp_in;
        end
      end else if (m_since < 1000000) begin
        m_since <= m_since + 1;
      end
    end
  end

  function automatic void expect_out(input int blank_cyc, output logic [3:0] e_an,
                                     output logic [6:0] e_seg, output logic e_dp,
                                     output logic e_frame);
    int   i;
    logic blanked;
    logic dpr;
    i       = int'(m_idx);
    e_an    = 4'b1111;
    e_seg   = 7'b1111111;
    e_dp    = 1'b1;
    e_frame = m_started && (m_since == 1) && (m_idx == 2'd0);
    if (m_started && (m_since > blank_cyc + 1)) begin
      dpr     = m_dps[i];
      blanked = m_lz && (i != 0) && ((m_snap >> (4 * i)) == 16'h0000);
      if (!blanked) begin
        e_an[i] = 1'b0;
        e_seg   = seg_tbl[(m_snap >> (4 * i)) & 16'hF];
        e_dp    = ~dpr;
      end else if (dpr) begin
        e_an[i] = 1'b0;
        e_dp    = 1'b0;
      end
    end
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clkin) begin
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed, ef;
    expect_out(500, ea, es, ed, ef);
    check("model an gap500", an_a, ea);
    check("model seg gap500", seg_a, es);
    check("model dp gap500", dp_a, ed);
    check("model frame gap500", frame_a, ef);
    expect_out(0, ea, es, ed, ef);
    check("model an gap0", an_b, ea);
    check("model seg gap0", seg_b, es);
    check("model dp gap0", dp_b, ed);
    check("model frame gap0", frame_b, ef);
  end

  // ---------------- directed stimulus ----------------
  int gap_a, gap_b, frames_a;

  // One strobe period: rise, hold high HALF cycles, low HALF cycles.
  // Counts dark-anode cycles and frame pulses seen during the period.
  task automatic tick_slot();
    gap_a    = 0;
    gap_b    = 0;
    frames_a = 0;
    @(posedge clkin);
    #2 clk_1kHz = 1'b1;
    for (int i = 0; i < 2 * HALF; i++) begin
      @(negedge clkin);
      if (an_a == 4'b1111) gap_a++;
      if (an_b == 4'b1111) gap_b++;
      if (frame_a) frames_a++;
      if (i == HALF - 1) #2 clk_1kHz = 1'b0;
      @(posedge clkin);
    end
  endtask

  task automatic slot(input string name, input logic [3:0] e_an,
                      input logic [6:0] e_seg, input logic e_dp);
    tick_slot();
    @(negedge clkin);
    check({name, " an"}, an_a, e_an);
    check({name, " seg"}, seg_a, e_seg);
    check({name, " dp"}, dp_a, e_dp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, held across a clock edge.
    clrn = 1'b0;
    #22;
    check("reset an", an_a, 4'b1111);
    check("reset seg", seg_a, 7'b1111111);
    check("reset dp", dp_a, 1'b1);
    check("reset frame", frame_a, 1'b0);
    #3 clrn = 1'b1;

    // No anode before the first strobe edge.
    repeat (100) @(posedge clkin);
    @(negedge clkin);
    check("idle before strobe", an_a, 4'b1111);

    // Scan order: first frame shows the reset snapshot (zeros).
    data = 16'h1234; blank_lz = 1'b0; dp_in = 4'b0000;
    slot("scan d1 pre", 4'b1101, 7'b1000000, 1'b1);
    slot("scan d2 pre", 4'b1011, 7'b1000000, 1'b1);
    slot("scan d3 pre", 4'b0111, 7'b1000000, 1'b1);
    slot("scan d0 4", 4'b1110, 7'b0011001, 1'b1);
    check("frame once at wrap", frames_a, 1);
    slot("scan d1 3", 4'b1101, 7'b0110000, 1'b1);
    check("no frame off wrap", frames_a, 0);
    slot("scan d2 2", 4'b1011, 7'b0100100, 1'b1);
    slot("scan d3 1", 4'b0111, 7'b1111001, 1'b1);
    slot("scan d0 again", 4'b1110, 7'b0011001, 1'b1);
    check("gap cycles 500", gap_a, 501);
    check("gap cycles 0", gap_b, 1);

    // Leading zeros: 0005 with blanking on.
    data = 16'h0005; blank_lz = 1'b1;
    repeat (3) tick_slot();
    slot("lz d0 5", 4'b1110, 7'b0010010, 1'b1);
    slot("lz d1 off", 4'b1111, 7'b1111111, 1'b1);
    slot("lz d2 off", 4'b1111, 7'b1111111, 1'b1);
    slot("lz d3 off", 4'b1111, 7'b1111111, 1'b1);
    slot("lz d0 5 again", 4'b1110, 7'b0010010, 1'b1);
    blank_lz = 1'b0;
    slot("nolz d1 0", 4'b1101, 7'b1000000, 1'b1);

    // All zero with a decimal point on digit 2.
    data = 16'h0000; dp_in = 4'b0100; blank_lz = 1'b1;
    repeat (2) tick_slot();
    slot("dp d0", 4'b1110, 7'b1000000, 1'b1);
    slot("dp d1 off", 4'b1111, 7'b1111111, 1'b1);
    slot("dp d2 point", 4'b1011, 7'b1111111, 1'b0);
    slot("dp d3 off", 4'b1111, 7'b1111111, 1'b1);
    slot("dp d0 again", 4'b1110, 7'b1000000, 1'b1);

    // Frame latching: ABCD, then FFFF written while idx=2.
    data = 16'hABCD; dp_in = 4'b0000; blank_lz = 1'b0;
    repeat (3) tick_slot();
    slot("latch d0 D", 4'b1110, 7'b0100001, 1'b1);
    slot("latch d1 C", 4'b1101, 7'b1000110, 1'b1);
    slot("latch d2 B", 4'b1011, 7'b0000011, 1'b1);
    data = 16'hFFFF;
    slot("latch d3 A", 4'b0111, 7'b0001000, 1'b1);
    slot("latch d0 F", 4'b1110, 7'b0001110, 1'b1);

    // Asynchronous reset in the middle of a DRIVE slot.
    @(posedge clkin);
    #2 clk_1kHz = 1'b1;
    repeat (600) @(posedge clkin);
    check("pre-reset driving", an_a, 4'b1101);
    #5 clrn = 1'b0;
    #1;
    check("async reset an", an_a, 4'b1111);
    check("async reset seg", seg_a, 7'b1111111);
    check("async reset an gap0", an_b, 4'b1111);
    @(posedge clkin);
    #2 clrn = 1'b1;

    // Strobe still high: one tick, first driven digit is digit 1 (zeros).
    for (int i = 0; i < 1500 && an_a == 4'b1111; i++) @(negedge clkin);
    check("after reset first digit", an_a, 4'b1101);
    check("after reset snapshot zero", seg_a, 7'b1000000);
    repeat (1000) @(negedge clkin);
    check("steady high single tick", an_a, 4'b1101);
    clk_1kHz = 1'b0;
    repeat (10) @(negedge clkin);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
